// File: rtl/game_clock_ctrl.sv
// Mine Quest game clock: HH:MM:SS up/down timer with a 1 Hz prescaler,
// pause/resume, preset load, time-up flag and up-count wrap or saturate.
module game_clock_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int HOURS_MAX     = 99,
    parameter int WRAP          = 1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       count_down,
    input  logic [6:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic       pause,
    input  logic       is_game_over,
    output logic [6:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       sec_tick,
    output logic       time_up
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0] H_MAX = 7'(HOURS_MAX);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    hours_q, hours_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          down_q, down_d;
    logic          running_q, running_d;
    logic          tick_q, tick_d;
    logic          time_up_q, time_up_d;

    logic [6:0] ld_h;
    logic [5:0] ld_m;
    logic [5:0] ld_s;
    logic       at_max;

    // Clamp the preset and detect the top of the up-count range
    always_comb begin
        ld_h = (load_hours > H_MAX) ? H_MAX : load_hours;
        ld_m = (load_minutes > 6'd59) ? 6'd59 : load_minutes;
        ld_s = (load_seconds > 6'd59) ? 6'd59 : load_seconds;
        at_max = (hours_q == H_MAX) && (min_q == 6'd59) && (sec_q == 6'd59);
    end

    // Next-state logic: game over beats start, start beats pause
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        hours_d   = hours_q;
        min_d     = min_q;
        sec_d     = sec_q;
        down_d    = down_q;
        tick_d    = 1'b0;
        time_up_d = time_up_q;
        if (is_game_over) begin
            if (state_q == S_RUN || state_q == S_PAUSED) begin
                state_d = S_DONE;
            end
        end else if (start) begin
            hours_d   = ld_h;
            min_d     = ld_m;
            sec_d     = ld_s;
            down_d    = count_down;
            presc_d   = '0;
            if (count_down && ld_h == 7'd0 && ld_m == 6'd0 && ld_s == 6'd0) begin
                state_d   = S_DONE;
                time_up_d = 1'b1;
            end else begin
                state_d   = S_RUN;
                time_up_d = 1'b0;
            end
        end else if (state_q == S_RUN) begin
            state_d = pause ? S_PAUSED : S_RUN;
            if (presc_q == P_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (!down_q) begin
                    if (at_max) begin
                        if (WRAP != 0) begin
                            hours_d = 7'd0;
                            min_d   = 6'd0;
                            sec_d   = 6'd0;
                        end else begin
                            tick_d    = 1'b0;
                            state_d   = S_DONE;
                            time_up_d = 1'b1;
                        end
                    end else if (sec_q != 6'd59) begin
                        sec_d = sec_q + 6'd1;
                    end else begin
                        sec_d = 6'd0;
                        if (min_q != 6'd59) begin
                            min_d = min_q + 6'd1;
                        end else begin
                            min_d   = 6'd0;
                            hours_d = hours_q + 7'd1;
                        end
                    end
                end else begin
                    if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                    end else begin
                        sec_d = 6'd59;
                        if (min_q != 6'd0) begin
                            min_d = min_q - 6'd1;
                        end else begin
                            min_d   = 6'd59;
                            hours_d = hours_q - 7'd1;
                        end
                    end
                    if (hours_d == 7'd0 && min_d == 6'd0 && sec_d == 6'd0) begin
                        state_d   = S_DONE;
                        time_up_d = 1'b1;
                    end
                end
            end else if (!pause) begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_q == S_PAUSED) begin
            if (!pause) begin
                state_d = S_RUN;
            end
        end
        running_d = (state_d == S_RUN);
    end

    // State and time registers
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            hours_q   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            down_q    <= 1'b0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            time_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hours_q   <= hours_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            down_q    <= down_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            time_up_q <= time_up_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = {1'b0, min_q};
    assign seconds  = {1'b0, sec_q};
    assign running  = running_q;
    assign sec_tick = tick_q;
    assign time_up  = time_up_q;

endmodule

// File: tb/tb_game_clock_ctrl.sv
// Directed bench for game_clock_ctrl (TICKS_PER_SEC=4), one wrapping and one
// saturating instance sharing stimulus; expected times are queued and popped per tick.
module tb_game_clock_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       count_down = 1'b0;
    logic [6:0] load_hours = '0;
    logic [5:0] load_minutes = '0;
    logic [5:0] load_seconds = '0;
    logic       pause = 1'b0;
    logic       is_game_over = 1'b0;

    logic [6:0] h1, m1, s1, h0, m0, s0;
    logic       run1, tick1, tu1, run0, tick0, tu0;

    int total = 0;
    int bad = 0;
    logic [20:0] sb[$];

    always #5 clk = ~clk;

    game_clock_ctrl #(.TICKS_PER_SEC(4), .HOURS_MAX(99), .WRAP(1)) u_w1 (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .count_down(count_down),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .pause(pause), .is_game_over(is_game_over),
        .hours(h1), .minutes(m1), .seconds(s1),
        .running(run1), .sec_tick(tick1), .time_up(tu1)
    );

    game_clock_ctrl #(.TICKS_PER_SEC(4), .HOURS_MAX(99), .WRAP(0)) u_w0 (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .count_down(count_down),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .pause(pause), .is_game_over(is_game_over),
        .hours(h0), .minutes(m0), .seconds(s0),
        .running(run0), .sec_tick(tick0), .time_up(tu0)
    );

    function automatic logic [20:0] hms(input int h, input int m, input int s);
        return {7'(h), 7'(m), 7'(s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_start(input logic cd, input int h, input int m, input int s);
        start = 1'b1;
        count_down = cd;
        load_hours = 7'(h);
        load_minutes = 6'(m);
        load_seconds = 6'(s);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_tick(input string tag, input int gap);
        int n;
        bit seen;
        logic [20:0] e;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = tick1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        e = sb.pop_front();
        chk(tag, 32'({h1, m1, s1}), 32'(e));
        if (gap > 0) chk({tag, "_gap"}, n, gap);
    endtask

    initial begin
        // reset state
        cyc(2);
        chk("rst_w1", 32'({h1, m1, s1, run1, tick1, tu1}), 32'd0);
        chk("rst_w0", 32'({h0, m0, s0, run0, tick0, tu0}), 32'd0);
        resetn = 1'b1;
        cyc(2);
        chk("idle_hold", 32'({h1, m1, s1, run1, tick1, tu1}), 32'd0);

        // up count from 0 through 01:00:00
        do_start(1'b0, 0, 0, 0);
        chk("up_running", 32'(run1), 32'd1);
        for (int i = 1; i <= 3600; i++) begin
            sb.push_back(hms(i / 3600, (i / 60) % 60, i % 60));
            expect_tick("up", 4);
        end

        // rollover: wrap vs saturate
        do_start(1'b0, 99, 59, 59);
        sb.push_back(hms(0, 0, 0));
        expect_tick("wrap", 4);
        chk("wrap_run", 32'({run1, tu1}), 32'b10);
        chk("sat_val", 32'({h0, m0, s0}), 32'(hms(99, 59, 59)));
        chk("sat_flags", 32'({run0, tu0, tick0}), 32'b010);

        // countdown 00:01:01 to zero
        do_start(1'b1, 0, 1, 1);
        for (int i = 60; i >= 0; i--) begin
            sb.push_back(hms(0, i / 60, i % 60));
            expect_tick("down", 4);
        end
        chk("down_end", 32'({run1, tu1}), 32'b01);
        cyc(8);
        chk("down_hold", 32'({h1, m1, s1, run1, tick1, tu1}), 32'b01);
        do_start(1'b1, 0, 0, 0);
        chk("down_zero", 32'({h1, m1, s1, run1, tick1, tu1}), 32'b01);

        // pause at prescaler 2
        do_start(1'b0, 0, 0, 0);
        cyc(2);
        pause = 1'b1;
        cyc(10);
        chk("pause_hold", 32'({h1, m1, s1, run1, tick1}), 32'd0);
        pause = 1'b0;
        cyc(1);
        chk("resume_run", 32'(run1), 32'd1);
        sb.push_back(hms(0, 0, 1));
        expect_tick("resume", 2);
        sb.push_back(hms(0, 0, 2));
        expect_tick("after_resume", 4);

        // game over in the tick cycle, start ignored while high
        cyc(3);
        is_game_over = 1'b1;
        start = 1'b1;
        cyc(1);
        chk("go_notick", 32'({h1, m1, s1, run1, tick1, tu1}), 32'({hms(0, 0, 2), 3'b000}));
        cyc(4);
        start = 1'b0;
        chk("go_hold", 32'({h1, m1, s1, run1, tick1, tu1}), 32'({hms(0, 0, 2), 3'b000}));
        is_game_over = 1'b0;
        cyc(3);
        chk("done_hold", 32'({h1, m1, s1, run1, tick1}), 32'({hms(0, 0, 2), 2'b00}));

        // clamp, then asynchronous reset mid-run
        do_start(1'b0, 120, 63, 60);
        chk("clamp", 32'({h1, m1, s1, run1, tu1}), 32'({hms(99, 59, 59), 2'b10}));
        cyc(2);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst", 32'({h1, m1, s1, run1, tick1, tu1}), 32'd0);
        chk("async_rst0", 32'({h0, m0, s0, run0, tick0, tu0}), 32'd0);
        cyc(1);
        resetn = 1'b1;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
